// File: rtl/grf_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : grf_read_arbiter
// Brief    : Round-robin sharing of the two-read-port GRF between ALU and LSU
//            issue, with drive/free handshakes on request and response sides.
// Revision : 1.0 - initial release
// ============================================================================
module grf_read_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_Drive_AluToArb_1,
    output logic              o_Free_ArbToAlu_1,
    input  logic [ADDR_W-1:0] i_AluRs1_5,
    input  logic [ADDR_W-1:0] i_AluRs2_5,
    input  logic              i_Drive_LsuToArb_1,
    output logic              o_Free_ArbToLsu_1,
    input  logic [ADDR_W-1:0] i_LsuRs1_5,
    input  logic [ADDR_W-1:0] i_LsuRs2_5,
    output logic              o_GrfRen_1,
    output logic [ADDR_W-1:0] o_GrfRaddr1_5,
    output logic [ADDR_W-1:0] o_GrfRaddr2_5,
    input  logic [DATA_W-1:0] i_GrfRdata1_32,
    input  logic [DATA_W-1:0] i_GrfRdata2_32,
    output logic              o_Drive_ArbToAlu_1,
    input  logic              i_Free_AluToArb_1,
    output logic              o_Drive_ArbToLsu_1,
    input  logic              i_Free_LsuToArb_1,
    output logic [DATA_W-1:0] o_OperandL_32,
    output logic [DATA_W-1:0] o_OperandR_32
);

    localparam logic c_ALU = 1'b0;
    localparam logic c_LSU = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            state_q;
    logic              rr_last_q;
    logic              owner_q;
    logic              ren_q;
    logic              drv_alu_q;
    logic              drv_lsu_q;
    logic [ADDR_W-1:0] rs1_q;
    logic [ADDR_W-1:0] rs2_q;
    logic [DATA_W-1:0] opl_q;
    logic [DATA_W-1:0] opr_q;

    logic              accept_d;
    logic              owner_d;
    logic              release_d;

    assign accept_d  = i_Drive_AluToArb_1 | i_Drive_LsuToArb_1;
    // LSU wins when it is alone, or when both ask and ALU was served last.
    assign owner_d   = i_Drive_LsuToArb_1 & (~i_Drive_AluToArb_1 | (rr_last_q == c_ALU));
    assign release_d = (owner_q == c_ALU) ? i_Free_AluToArb_1 : i_Free_LsuToArb_1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            rr_last_q <= c_LSU;
            owner_q   <= c_ALU;
            ren_q     <= 1'b0;
            drv_alu_q <= 1'b0;
            drv_lsu_q <= 1'b0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            opl_q     <= '0;
            opr_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept_d) begin
                        owner_q <= owner_d;
                        rs1_q   <= owner_d ? i_LsuRs1_5 : i_AluRs1_5;
                        rs2_q   <= owner_d ? i_LsuRs2_5 : i_AluRs2_5;
                        ren_q   <= 1'b1;
                        state_q <= S_READ;
                    end
                end
                S_READ: begin
                    ren_q     <= 1'b0;
                    // x0 reads as zero whatever the macro returns.
                    opl_q     <= (rs1_q == '0) ? '0 : i_GrfRdata1_32;
                    opr_q     <= (rs2_q == '0) ? '0 : i_GrfRdata2_32;
                    drv_alu_q <= (owner_q == c_ALU);
                    drv_lsu_q <= (owner_q == c_LSU);
                    rr_last_q <= owner_q;
                    state_q   <= S_RESP;
                end
                S_RESP: begin
                    if (release_d) begin
                        drv_alu_q <= 1'b0;
                        drv_lsu_q <= 1'b0;
                        state_q   <= S_IDLE;
                    end
                end
                default: begin
                    ren_q     <= 1'b0;
                    drv_alu_q <= 1'b0;
                    drv_lsu_q <= 1'b0;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end

    assign o_Free_ArbToAlu_1  = (state_q == S_IDLE);
    assign o_Free_ArbToLsu_1  = (state_q == S_IDLE);
    assign o_GrfRen_1         = ren_q;
    assign o_GrfRaddr1_5      = rs1_q;
    assign o_GrfRaddr2_5      = rs2_q;
    assign o_Drive_ArbToAlu_1 = drv_alu_q;
    assign o_Drive_ArbToLsu_1 = drv_lsu_q;
    assign o_OperandL_32      = opl_q;
    assign o_OperandR_32      = opr_q;

endmodule
`default_nettype wire

// File: tb/tb_grf_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_grf_read_arbiter
// Brief    : Directed plus randomized bench for grf_read_arbiter against a
//            transaction-level model of arbitration order and operand values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_grf_read_arbiter;
    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          alu_drv = 1'b0, lsu_drv = 1'b0;
    logic [AW-1:0] alu_rs1 = '0, alu_rs2 = '0, lsu_rs1 = '0, lsu_rs2 = '0;
    logic          alu_free = 1'b0, lsu_free = 1'b0;
    logic          free_alu, free_lsu, ren, drv_alu, drv_lsu;
    logic [AW-1:0] raddr1, raddr2;
    logic [DW-1:0] rd1, rd2, opl, opr;

    logic [DW-1:0] mem [32];
    assign rd1 = mem[raddr1];
    assign rd2 = mem[raddr2];

    grf_read_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rstn(rstn),
        .i_Drive_AluToArb_1(alu_drv), .o_Free_ArbToAlu_1(free_alu),
        .i_AluRs1_5(alu_rs1), .i_AluRs2_5(alu_rs2),
        .i_Drive_LsuToArb_1(lsu_drv), .o_Free_ArbToLsu_1(free_lsu),
        .i_LsuRs1_5(lsu_rs1), .i_LsuRs2_5(lsu_rs2),
        .o_GrfRen_1(ren), .o_GrfRaddr1_5(raddr1), .o_GrfRaddr2_5(raddr2),
        .i_GrfRdata1_32(rd1), .i_GrfRdata2_32(rd2),
        .o_Drive_ArbToAlu_1(drv_alu), .i_Free_AluToArb_1(alu_free),
        .o_Drive_ArbToLsu_1(drv_lsu), .i_Free_LsuToArb_1(lsu_free),
        .o_OperandL_32(opl), .o_OperandR_32(opr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: who is waiting, what they want, who was served last.
    bit            pend [2];
    logic [AW-1:0] m_rs1 [2];
    logic [AW-1:0] m_rs2 [2];
    bit            last = 1'b1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apply();
        alu_drv = pend[0]; alu_rs1 = m_rs1[0]; alu_rs2 = m_rs2[0];
        lsu_drv = pend[1]; lsu_rs1 = m_rs1[1]; lsu_rs2 = m_rs2[1];
    endtask

    task automatic set_free(input bit a, input bit l);
        alu_free = a; lsu_free = l;
    endtask

    function automatic logic [DW-1:0] grf_val(input logic [AW-1:0] idx);
        return (idx == 0) ? '0 : mem[idx];
    endfunction

    task automatic new_req(input int r, input logic [AW-1:0] a, input logic [AW-1:0] b);
        pend[r] = 1'b1; m_rs1[r] = a; m_rs2[r] = b;
    endtask

    // Runs one full transaction starting and ending at a negedge in IDLE.
    task automatic serve(input int hold, output int t_acc);
        bit w;
        logic [DW-1:0] el, er;
        w  = (pend[0] && pend[1]) ? ~last : pend[1];
        el = grf_val(m_rs1[w]);
        er = grf_val(m_rs2[w]);
        apply();
        chk("idle_free_alu", free_alu, 1);
        chk("idle_free_lsu", free_lsu, 1);
        @(posedge clk); #1;
        t_acc = cyc;
        pend[w] = 1'b0;
        apply();
        @(negedge clk);
        chk("read_ren", ren, 1);
        chk("read_addr1", raddr1, m_rs1[w]);
        chk("read_addr2", raddr2, m_rs2[w]);
        chk("read_free", {free_alu, free_lsu}, 0);
        chk("read_drive", {drv_alu, drv_lsu}, 0);
        @(posedge clk); @(negedge clk);
        chk("resp_drive", {drv_alu, drv_lsu}, w ? 2'b01 : 2'b10);
        chk("resp_L", opl, el);
        chk("resp_R", opr, er);
        chk("resp_ren", ren, 0);
        last = w;
        for (int i = 0; i < hold; i++) begin
            set_free(w, ~w);
            @(posedge clk); @(negedge clk);
            chk("hold_drive", {drv_alu, drv_lsu}, w ? 2'b01 : 2'b10);
            chk("hold_L", opl, el);
            chk("hold_R", opr, er);
            chk("hold_ren", ren, 0);
            chk("hold_free", {free_alu, free_lsu}, 0);
        end
        set_free(~w, w);
        @(posedge clk); #1;
        set_free(0, 0);
        @(negedge clk);
        chk("rel_drive", {drv_alu, drv_lsu}, 0);
        chk("rel_free", {free_alu, free_lsu}, 2'b11);
        chk("rel_ren", ren, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, tp;
        for (int i = 0; i < 32; i++) mem[i] = $urandom;
        mem[0] = 32'hDEAD;
        mem[3] = 32'h11;
        mem[7] = 32'h22;
        for (int r = 0; r < 2; r++) begin
            pend[r] = 0; m_rs1[r] = '0; m_rs2[r] = '0;
        end

        // Reset state
        #2;
        chk("rst_drive", {drv_alu, drv_lsu}, 0);
        chk("rst_ren", ren, 0);
        chk("rst_addr", {raddr1, raddr2}, 0);
        chk("rst_ops", {opl, opr}, 0);
        @(negedge clk); @(negedge clk);
        rstn = 1'b1;

        // Single ALU request with known register contents
        new_req(0, 5'd3, 5'd7);
        serve(0, t);
        chk("t1_L_const", opl, 32'h11);
        chk("t1_R_const", opr, 32'h22);

        // Simultaneous requests alternate
        for (int k = 0; k < 4; k++) begin
            if (!pend[0]) new_req(0, 5'($urandom_range(1, 31)), 5'($urandom_range(1, 31)));
            if (!pend[1]) new_req(1, 5'($urandom_range(1, 31)), 5'($urandom_range(1, 31)));
            serve(0, t);
        end
        if (pend[1]) serve(0, t);
        if (pend[0]) serve(0, t);

        // x0 reads as zero
        new_req(0, 5'd0, 5'd5);
        serve(0, t);
        chk("t3_L_zero", opl, 0);

        // Long hold by LSU
        new_req(1, 5'd9, 5'd0);
        serve(10, t);

        // Reset during READ
        new_req(0, 5'd4, 5'd6);
        apply();
        @(posedge clk); #1;
        pend[0] = 0; apply();
        @(negedge clk);
        chk("rr_pre_ren", ren, 1);
        rstn = 1'b0; #1;
        chk("rr_ren", ren, 0);
        chk("rr_drive", {drv_alu, drv_lsu}, 0);
        @(negedge clk);
        rstn = 1'b1; last = 1'b1;

        // Reset during RESP
        new_req(0, 5'd4, 5'd6);
        apply();
        @(posedge clk); #1;
        pend[0] = 0; apply();
        @(posedge clk); @(negedge clk);
        chk("rs_pre_drive", drv_alu, 1);
        rstn = 1'b0; #1;
        chk("rs_drive", {drv_alu, drv_lsu}, 0);
        chk("rs_ren", ren, 0);
        chk("rs_ops", {opl, opr}, 0);
        @(negedge clk);
        rstn = 1'b1; last = 1'b1;
        new_req(0, 5'd1, 5'd2);
        new_req(1, 5'd8, 5'd10);
        serve(0, t);
        serve(0, t);

        // Back-to-back ALU requests: accepts 3 cycles apart
        new_req(0, 5'd11, 5'd12);
        serve(0, tp);
        for (int k = 0; k < 3; k++) begin
            new_req(0, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            serve(0, t);
            chk("b2b_spacing", t - tp, 3);
            tp = t;
        end

        // Randomized traffic
        for (int it = 0; it < 40; it++) begin
            for (int r = 0; r < 2; r++) begin
                if (!pend[r] && $urandom_range(0, 1) == 1)
                    new_req(r, ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                               ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31)));
            end
            if (pend[0] || pend[1]) begin
                serve($urandom_range(0, 3), t);
            end else begin
                apply();
                @(posedge clk); @(negedge clk);
                chk("idle_ren", ren, 0);
                chk("idle_drive", {drv_alu, drv_lsu}, 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
